// File: rtl/vec_inst_q_pkg.sv
// Shared types for the vector instruction queue: FSM states and entry layout.
package vec_inst_q_pkg;

   localparam int unsigned VQ_XLEN = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2
   } vq_state_e;

   typedef struct packed {
      logic [VQ_XLEN-1:0] inst;
      logic [VQ_XLEN-1:0] rs1;
      logic [VQ_XLEN-1:0] rs2;
   } vq_entry_t;

endpackage

// File: rtl/vec_sync_fifo.sv
// In-order entry storage with occupancy tracking and a synchronous clear.
module vec_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 96
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         clr_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // A full queue never accepts, even if the head leaves in the same cycle.
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o && !clr_i;
   assign do_pop  = pop_i && !empty_o && !clr_i;
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Next pointers and occupancy; clear overrides any push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
         else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/vec_inst_queue.sv
// Decoupling queue between the scalar core and the vector datapath:
// buffers instructions with operands and presents the head one at a time.
module vec_inst_queue
   import vec_inst_q_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = VQ_XLEN
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         sp_valid,
   output logic                         sp_ready,
   input  logic [XLEN-1:0]              sp_inst,
   input  logic [XLEN-1:0]              sp_rs1,
   input  logic [XLEN-1:0]              sp_rs2,
   input  logic                         flush,
   output logic [XLEN-1:0]              instruction,
   output logic [XLEN-1:0]              rs1_data,
   output logic [XLEN-1:0]              rs2_data,
   output logic                         issue,
   input  logic                         is_vec,
   input  logic                         inst_done,
   output logic                         retire,
   output logic                         illegal_inst,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   vq_state_e        state_q, state_d;
   logic             ready_q;
   vq_entry_t        wr_entry;
   vq_entry_t        head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop_c;
   logic             issue_c;
   logic             retire_c;
   logic             illegal_c;
   logic [CNT_W-1:0] fifo_count;

   assign wr_entry = '{inst: sp_inst, rs1: sp_rs1, rs2: sp_rs2};

   // Ready stays low until the first clock after reset release, and during flush.
   assign sp_ready = ready_q && !fifo_full && !flush;

   vec_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(vq_entry_t))
   ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .clr_i   (flush),
      .push_i  (sp_valid && sp_ready),
      .pop_i   (pop_c),
      .wdata_i (wr_entry),
      .rdata_o (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Ready-enable register: arms acceptance one cycle after reset release.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) ready_q <= 1'b0;
      else        ready_q <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state, pop request and event pulses; flush drops the head silently.
   always_comb begin
      state_d   = state_q;
      pop_c     = 1'b0;
      issue_c   = 1'b0;
      retire_c  = 1'b0;
      illegal_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = ISSUE;
         end
         ISSUE: begin
            issue_c = 1'b1;
            if (!is_vec) begin
               illegal_c = 1'b1;
               pop_c     = 1'b1;
               state_d   = (fifo_count > CNT_W'(1)) ? ISSUE : IDLE;
            end else begin
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (inst_done) begin
               retire_c = 1'b1;
               pop_c    = 1'b1;
               state_d  = (fifo_count > CNT_W'(1)) ? ISSUE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d   = IDLE;
         pop_c     = 1'b0;
         retire_c  = 1'b0;
         illegal_c = 1'b0;
      end
   end

   assign issue        = issue_c;
   assign retire       = retire_c;
   assign illegal_inst = illegal_c;
   assign count        = fifo_count;

   // Head operands are visible only while an entry is being issued or executed.
   assign instruction = (state_q != IDLE) ? head.inst : '0;
   assign rs1_data    = (state_q != IDLE) ? head.rs1  : '0;
   assign rs2_data    = (state_q != IDLE) ? head.rs2  : '0;

endmodule
